// File: rtl/ccd_exp_ctrl.sv
// Exposure execution controller: XSUB charge-clear pulse, then an exposure window of
// L whole lines plus P pixel clocks, ending in a one-cycle readout request.
module ccd_exp_ctrl #(
    parameter int REG_WD        = 16,
    parameter int SUB_PULSE_PIX = 64
) (
    input  logic              pixclk,
    input  logic              reset,
    input  logic              i_exposure_start,
    input  logic              i_hend,
    input  logic              i_triggersel_m,
    input  logic              i_strobe_en,
    input  logic [REG_WD-1:0] iv_exp_lines,
    input  logic [REG_WD-1:0] iv_exp_pix,
    output logic              o_xsub,
    output logic              o_exposing,
    output logic              o_strobe,
    output logic              o_readout_req,
    output logic              o_busy,
    output logic              o_overrun,
    output logic [1:0]        dbg_state
);

    localparam int SUB_W = (SUB_PULSE_PIX > 1) ? $clog2(SUB_PULSE_PIX) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_PULSE_PIX - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SUB    = 2'd1,
        EXPOSE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [SUB_W-1:0]  sub_cnt, sub_cnt_nx;
    logic [REG_WD-1:0] lc, lc_nx, pc, pc_nx;
    logic [REG_WD-1:0] lines_sh, lines_sh_nx, pix_sh, pix_sh_nx;
    logic              trig_q;
    logic              abort;
    logic              xsub_nx, exposing_nx, strobe_nx, readout_nx, busy_nx, overrun_nx;

    // Any change of acquisition mode relative to last cycle cancels the exposure.
    assign abort     = i_triggersel_m ^ trig_q;
    assign dbg_state = state;

    always_comb begin
        state_nx    = state;
        sub_cnt_nx  = sub_cnt;
        lc_nx       = lc;
        pc_nx       = pc;
        lines_sh_nx = lines_sh;
        pix_sh_nx   = pix_sh;
        overrun_nx  = 1'b0;

        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (i_exposure_start) begin
                        lines_sh_nx = iv_exp_lines;
                        pix_sh_nx   = iv_exp_pix;
                        sub_cnt_nx  = '0;
                        lc_nx       = '0;
                        pc_nx       = '0;
                        state_nx    = SUB;
                    end
                end
                SUB: begin
                    overrun_nx = i_exposure_start;
                    if (sub_cnt == SUB_LAST) state_nx = EXPOSE;
                    else                     sub_cnt_nx = sub_cnt + 1'b1;
                end
                EXPOSE: begin
                    overrun_nx = i_exposure_start;
                    // Line phase first; the pixel counter only runs once all lines are seen.
                    if (lc != lines_sh) begin
                        if (i_hend) lc_nx = lc + 1'b1;
                    end else if (pc == pix_sh) begin
                        state_nx = DONE;
                    end else begin
                        pc_nx = pc + 1'b1;
                    end
                end
                DONE: begin
                    overrun_nx = i_exposure_start;
                    state_nx   = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end

        xsub_nx     = (state_nx == SUB);
        exposing_nx = (state_nx == EXPOSE);
        readout_nx  = (state_nx == DONE);
        busy_nx     = (state_nx != IDLE);
        strobe_nx   = !abort && o_exposing && i_strobe_en;
    end

    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            sub_cnt       <= '0;
            lc            <= '0;
            pc            <= '0;
            lines_sh      <= '0;
            pix_sh        <= '0;
            trig_q        <= 1'b0;
            o_xsub        <= 1'b0;
            o_exposing    <= 1'b0;
            o_strobe      <= 1'b0;
            o_readout_req <= 1'b0;
            o_busy        <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            state         <= state_nx;
            sub_cnt       <= sub_cnt_nx;
            lc            <= lc_nx;
            pc            <= pc_nx;
            lines_sh      <= lines_sh_nx;
            pix_sh        <= pix_sh_nx;
            trig_q        <= i_triggersel_m;
            o_xsub        <= xsub_nx;
            o_exposing    <= exposing_nx;
            o_strobe      <= strobe_nx;
            o_readout_req <= readout_nx;
            o_busy        <= busy_nx;
            o_overrun     <= overrun_nx;
        end
    end

endmodule

// File: doc/ccd_exp_ctrl.md
# ccd_exp_ctrl

Exposure execution controller for the CCD sensor path, sitting directly downstream of the trigger stage. It consumes the single-cycle exposure-start pulse from either continuous or trigger mode. It then drives the electronic-shutter (XSUB) charge-clear pulse and times the exposure window in whole lines plus a pixel-clock fine offset. At the end it raises a one-cycle readout request for the vertical-transfer/readout stage.

## Interface
Parameters:
- REG_WD, 16, width of register-file values and counters.
- SUB_PULSE_PIX, 64, XSUB pulse width in pixclk cycles (≥1).

Ports:
- pixclk  input  1  pixel clock; all logic on rising edge.
- reset  input  1  reset, asynchronous, active-high.
- i_exposure_start  input  1  one-cycle exposure start pulse from trigger stage.
- i_hend  input  1  one-cycle line-end pulse from the timing generator.
- i_triggersel_m  input  1  acquisition mode (0 continuous, 1 trigger); any change aborts.
- i_strobe_en  input  1  flash strobe enable.
- iv_exp_lines  input  REG_WD  exposure length, whole lines (L).
- iv_exp_pix  input  REG_WD  fine exposure extension, pixclk cycles (P).
- o_xsub  output  1  electronic-shutter charge-clear pulse.
- o_exposing  output  1  exposure window active.
- o_strobe  output  1  o_exposing AND i_strobe_en (registered).
- o_readout_req  output  1  one-cycle pulse at end of exposure.
- o_busy  output  1  high whenever state ≠ IDLE.
- o_overrun  output  1  one-cycle pulse: start pulse ignored because busy.

## Operation
- States: IDLE → SUB → EXPOSE → DONE → IDLE.
- IDLE: on i_exposure_start, latch L, P into shadow registers, clear counters, go SUB. L/P changes after latch have no effect on the current exposure.
- SUB: o_xsub high. A sub counter runs 0..SUB_PULSE_PIX-1. On the last count, go EXPOSE.
- EXPOSE: o_exposing high.
  - Line counter lc starts at 0 and increments on each i_hend while lc < L.
  - Once lc == L, pixel counter pc increments every cycle.
  - The cycle in which lc == L and pc == P, go DONE.
- DONE: o_readout_req high for exactly one cycle, then IDLE.
- L = 0 skips the line phase. L = 0 and P = 0 gives the minimum window of 1 cycle.
- Counters are REG_WD wide. They cannot wrap because they stop at the latched target.
- Busy start: i_exposure_start in any state other than IDLE (including DONE) is ignored, and o_overrun pulses the next cycle.
- Abort: i_triggersel_m is compared against its value registered one cycle earlier. Any difference forces IDLE on the next cycle with all outputs low and no o_readout_req. Abort has priority over start, counting and DONE.
  - A start in the same cycle as an abort is dropped without o_overrun.
- Reset, including mid-exposure: all outputs 0, state IDLE, counters and shadows 0. The registered copy of i_triggersel_m resets to 0, so a high input after reset produces one abort cycle in IDLE, which is harmless.

## Timing
- All outputs are registered. Reset value is 0 for o_xsub, o_exposing, o_strobe, o_readout_req, o_busy and o_overrun.
- Start sampled at cycle N:
  - o_busy and o_xsub are high from N+1.
  - o_xsub is high for exactly SUB_PULSE_PIX cycles, N+1 .. N+SUB_PULSE_PIX.
  - o_exposing rises at N+SUB_PULSE_PIX+1. There is no gap and no overlap with o_xsub.
- L = 0: o_exposing stays high for exactly P+1 cycles.
- L > 0: if the L-th i_hend is sampled at cycle H, lc == L at H+1. o_exposing then stays high through H+1+P.
  - i_hend seen on the first EXPOSE cycle counts.
  - i_hend during SUB is ignored.
- o_readout_req occupies the first cycle after o_exposing falls. o_busy falls the cycle after that.
- o_strobe follows o_exposing with one cycle of extra latency, gated by i_strobe_en.
- Back-to-back: the earliest accepted next start is the first cycle with o_busy low.

## Test plan
- SUB_PULSE_PIX = 4, L = 0, P = 10, start at cycle 0 → o_xsub high cycles 1–4; o_exposing high 5–15; o_readout_req at 16; o_busy low at 17.
- L = 2, P = 0, i_hend every 20 cycles from exposing start (first on cycle 0 of EXPOSE) → o_exposing falls 2 cycles after the 2nd hend; i_hend during SUB has no effect.
- Second start during EXPOSE and another during DONE → o_overrun pulse for each, and the timing of the running exposure is unchanged.
- Toggle i_triggersel_m mid-EXPOSE → next cycle o_exposing = 0 and o_busy = 0, with no o_readout_req; a start in the abort cycle produces no o_overrun.
- Change iv_exp_pix from 10 to 100 during SUB → window still P = 10; i_strobe_en = 1 → o_strobe matches o_exposing delayed 1 cycle.
- Assert reset mid-SUB → all outputs 0 asynchronously; after release, a new start gives nominal timing.
